core_axi2apb_bridge: RTL and testbench

//  Single-outstanding AXI4-Lite slave to APB4 master bridge. Feeds the core peripheral
//  APB fabric (address decode to cfgreg/dbgmon/intc sits directly downstream).

---
 rtl/core_axi2apb_bridge_if.sv | 55 +++++
 rtl/core_axi2apb_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_core_axi2apb_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_axi2apb_bridge_if.sv
// AXI4-Lite slave side and APB4 master side of the core peripheral bridge,
// bundled so the bridge and its environment share one port list.
interface core_axi2apb_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   logic              psel;
   logic              penable;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [STRB_W-1:0] pstrb;
   logic [2:0]        pprot;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   // Bridge view.
   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready, prdata, pready, pslverr,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
             psel, penable, paddr, pwrite, pstrb, pprot, pwdata
   );

   // AXI master plus APB slave view.
   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready, prdata, pready, pslverr,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
             psel, penable, paddr, pwrite, pstrb, pprot, pwdata
   );
endinterface

// File: rtl/core_axi2apb_bridge.sv
// Single-outstanding AXI4-Lite to APB4 bridge: one SETUP/ACCESS transfer per
// AXI request, read/write tie arbitration and an optional ACCESS timeout.
module core_axi2apb_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                  clk,
   input  logic                  rstn,
   core_axi2apb_bridge_if.slave  bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              aw_hold_q, aw_hold_d;
   logic              w_hold_q, w_hold_d;
   logic              ar_hold_q, ar_hold_d;
   logic              awready_q, wready_q, arready_q;
   logic              sel_wr_q, sel_wr_d;
   logic              rr_last_wr_q, rr_last_wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [ADDR_W-1:0] awaddr_q, araddr_q;
   logic [2:0]        awprot_q, arprot_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;

   logic aw_hs, w_hs, ar_hs, timeout_hit, acc_exit, resp_hs;
   logic [1:0] resp_code;

   assign aw_hs       = bus.awvalid & awready_q;
   assign w_hs        = bus.wvalid & wready_q;
   assign ar_hs       = bus.arvalid & arready_q;
   assign timeout_hit = (TIMEOUT > 0) && !bus.pready && (cnt_q == CNT_LAST);
   assign acc_exit    = (state_q == ACCESS) && (bus.pready || timeout_hit);
   assign resp_code   = (bus.pready && !bus.pslverr) ? 2'b00 : 2'b10;
   assign resp_hs     = (bvalid_q & bus.bready) | (rvalid_q & bus.rready);

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.arready = arready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;
   assign bus.rdata   = rdata_q;

   // Holding flags: set on handshake, released as soon as ACCESS ends so the
   // next request can be captured while the response is still waiting.
   always_comb begin
      aw_hold_d = aw_hold_q;
      w_hold_d  = w_hold_q;
      ar_hold_d = ar_hold_q;
      if (acc_exit && sel_wr_q) begin
         aw_hold_d = 1'b0;
         w_hold_d  = 1'b0;
      end
      if (acc_exit && !sel_wr_q) ar_hold_d = 1'b0;
      if (aw_hs) aw_hold_d = 1'b1;
      if (w_hs)  w_hold_d  = 1'b1;
      if (ar_hs) ar_hold_d = 1'b1;
   end

   always_comb begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (bvalid_q && bus.bready) begin
         bvalid_d = 1'b0;
         bresp_d  = 2'b00;
      end
      if (rvalid_q && bus.rready) begin
         rvalid_d = 1'b0;
         rresp_d  = 2'b00;
         rdata_d  = '0;
      end
      if (acc_exit) begin
         if (sel_wr_q) begin
            bvalid_d = 1'b1;
            bresp_d  = resp_code;
         end else begin
            rvalid_d = 1'b1;
            rresp_d  = resp_code;
            rdata_d  = bus.pready ? bus.prdata : '0;
         end
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         aw_hold_q    <= 1'b0;
         w_hold_q     <= 1'b0;
         ar_hold_q    <= 1'b0;
         awready_q    <= 1'b0;
         wready_q     <= 1'b0;
         arready_q    <= 1'b0;
         sel_wr_q     <= 1'b0;
         rr_last_wr_q <= 1'b1;
         cnt_q        <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         rvalid_q     <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         aw_hold_q    <= aw_hold_d;
         w_hold_q     <= w_hold_d;
         ar_hold_q    <= ar_hold_d;
         awready_q    <= ~aw_hold_d;
         wready_q     <= ~w_hold_d;
         arready_q    <= ~ar_hold_d;
         sel_wr_q     <= sel_wr_d;
         rr_last_wr_q <= rr_last_wr_d;
         cnt_q        <= cnt_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
      end
   end

   // Request payloads; only observed while their holding flag is set.
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         awaddr_q <= bus.awaddr;
         awprot_q <= bus.awprot;
      end
      if (w_hs) begin
         wdata_q <= bus.wdata;
         wstrb_q <= bus.wstrb;
      end
      if (ar_hs) begin
         araddr_q <= bus.araddr;
         arprot_q <= bus.arprot;
      end
   end

   // rr_last_wr_q set means a write wins the next read/write tie.
   always_comb begin
      state_d      = state_q;
      sel_wr_d     = sel_wr_q;
      rr_last_wr_d = rr_last_wr_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (aw_hold_q && w_hold_q && ar_hold_q) begin
               sel_wr_d     = rr_last_wr_q;
               rr_last_wr_d = ~rr_last_wr_q;
               state_d      = SETUP;
            end else if (aw_hold_q && w_hold_q) begin
               sel_wr_d = 1'b1;
               state_d  = SETUP;
            end else if (ar_hold_q) begin
               sel_wr_d = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (acc_exit) state_d = RESP;
         end
         RESP: begin
            if (resp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.psel    = (state_q == SETUP) || (state_q == ACCESS);
      bus.penable = (state_q == ACCESS);
      bus.pwrite  = bus.psel & sel_wr_q;
      bus.paddr   = '0;
      bus.pprot   = 3'b000;
      bus.pwdata  = '0;
      bus.pstrb   = '0;
      if (bus.psel) begin
         bus.paddr = sel_wr_q ? awaddr_q : araddr_q;
         bus.pprot = sel_wr_q ? awprot_q : arprot_q;
         if (sel_wr_q) begin
            bus.pwdata = wdata_q;
            bus.pstrb  = wstrb_q;
         end
      end
   end
endmodule

// File: tb/tb_core_axi2apb_bridge.sv
// Directed bench for core_axi2apb_bridge with a tiny APB slave driven from
// bench variables and a log of completed APB transfers.
module tb_core_axi2apb_bridge;
   logic clk = 1'b0;
   logic rstn;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   core_axi2apb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   core_axi2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wd;
   } xfer_t;
   xfer_t xq[$];

   always @(negedge clk)
      if (bus.psel && bus.penable && bus.pready)
         xq.push_back('{wr: bus.pwrite, addr: bus.paddr, strb: bus.pstrb, wd: bus.pwdata});

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic issue_ar(input logic [31:0] a);
      @(posedge clk); #1 bus.arvalid = 1'b1; bus.araddr = a; bus.arprot = 3'b001;
      @(posedge clk); #1 bus.arvalid = 1'b0;
   endtask

   task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1 bus.awvalid = 1'b1; bus.awaddr = a; bus.awprot = 3'b000;
      bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
      @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
   endtask

   task automatic wait_rvalid(input string tag);
      int k = 0;
      while (!bus.rvalid && k < 30) begin @(negedge clk); k++; end
      chk(tag, 64'(bus.rvalid), 64'd1);
   endtask

   task automatic wait_bvalid(input string tag);
      int k = 0;
      while (!bus.bvalid && k < 30) begin @(negedge clk); k++; end
      chk(tag, 64'(bus.bvalid), 64'd1);
   endtask

   task automatic wait_xfers(input int n);
      int k = 0;
      while (xq.size() < n && k < 40) begin @(negedge clk); k++; end
      chk("xfer_count", 64'(xq.size()), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1);
   end

   initial begin
      int pen;
      rstn = 1'b0;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
      bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0; bus.rready = 1'b0;
      bus.prdata = '0; bus.pready = 1'b1; bus.pslverr = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_awready", 64'(bus.awready), 64'd0);
      chk("rst_arready", 64'(bus.arready), 64'd0);
      chk("rst_psel", 64'(bus.psel), 64'd0);
      chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
      do_reset();
      @(negedge clk);
      chk("post_rst_awready", 64'(bus.awready), 64'd1);

      // zero-wait read: SETUP N+1, ACCESS N+2, rvalid N+3
      bus.prdata = 32'h1234_5678;
      issue_ar(32'h0000_0040);
      @(negedge clk);
      chk("rd_idle_psel", 64'(bus.psel), 64'd0);
      @(negedge clk);
      chk("rd_setup_psel", 64'({bus.psel, bus.penable}), 64'h2);
      chk("rd_setup_paddr", 64'(bus.paddr), 64'h40);
      chk("rd_setup_pwrite", 64'(bus.pwrite), 64'd0);
      chk("rd_setup_pstrb", 64'(bus.pstrb), 64'd0);
      @(negedge clk);
      chk("rd_access", 64'({bus.psel, bus.penable}), 64'h3);
      chk("rd_access_rvalid", 64'(bus.rvalid), 64'd0);
      @(negedge clk);
      chk("rd_rvalid", 64'(bus.rvalid), 64'd1);
      chk("rd_rdata", 64'(bus.rdata), 64'h1234_5678);
      chk("rd_rresp", 64'(bus.rresp), 64'd0);
      chk("rd_resp_psel", 64'(bus.psel), 64'd0);
      bus.rready = 1'b1;
      @(negedge clk);
      chk("rd_rvalid_drop", 64'(bus.rvalid), 64'd0);
      chk("rd_rdata_clear", 64'(bus.rdata), 64'd0);
      bus.rready = 1'b0;

      // W two cycles ahead of AW
      @(posedge clk); #1 bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'b0101;
      @(posedge clk); #1 bus.wvalid = 1'b0;
      @(negedge clk);
      chk("w_held_wready", 64'(bus.wready), 64'd0);
      chk("w_only_psel", 64'(bus.psel), 64'd0);
      @(posedge clk); #1 bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0080;
      @(posedge clk); #1 bus.awvalid = 1'b0;
      @(negedge clk);
      chk("wr_idle_bvalid", 64'(bus.bvalid), 64'd0);
      @(negedge clk);
      chk("wr_setup_pwrite", 64'(bus.pwrite), 64'd1);
      chk("wr_setup_pstrb", 64'(bus.pstrb), 64'h5);
      chk("wr_setup_pwdata", 64'(bus.pwdata), 64'hCAFE_F00D);
      chk("wr_setup_paddr", 64'(bus.paddr), 64'h80);
      @(negedge clk);
      chk("wr_access_bvalid", 64'(bus.bvalid), 64'd0);
      @(negedge clk);
      chk("wr_bvalid", 64'(bus.bvalid), 64'd1);
      chk("wr_bresp", 64'(bus.bresp), 64'd0);
      chk("wr_resp_pwdata", 64'(bus.pwdata), 64'd0);
      bus.bready = 1'b1;
      @(negedge clk);
      chk("wr_bvalid_drop", 64'(bus.bvalid), 64'd0);
      bus.bready = 1'b0;

      // simultaneous read and write: write first after reset, then alternate
      do_reset();
      xq.delete();
      bus.bready = 1'b1; bus.rready = 1'b1;
      @(posedge clk); #1 bus.arvalid = 1'b1; bus.araddr = 32'h0000_0010;
      bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0020;
      bus.wvalid = 1'b1; bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF;
      @(posedge clk); #1 bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      wait_xfers(2);
      if (xq.size() >= 2) begin
         chk("arb1_first_wr", 64'(xq[0].wr), 64'd1);
         chk("arb1_first_addr", 64'(xq[0].addr), 64'h20);
         chk("arb1_second_wr", 64'(xq[1].wr), 64'd0);
         chk("arb1_read_pstrb", 64'(xq[1].strb), 64'd0);
      end
      repeat (4) @(negedge clk);
      @(posedge clk); #1 bus.arvalid = 1'b1; bus.araddr = 32'h0000_0030;
      bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0034;
      bus.wvalid = 1'b1; bus.wdata = 32'h3333_4444; bus.wstrb = 4'hC;
      @(posedge clk); #1 bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      wait_xfers(4);
      if (xq.size() >= 4) begin
         chk("arb2_first_wr", 64'(xq[2].wr), 64'd0);
         chk("arb2_second_wr", 64'(xq[3].wr), 64'd1);
         chk("arb2_second_data", 64'(xq[3].wd), 64'h3333_4444);
      end
      repeat (4) @(negedge clk);
      bus.bready = 1'b0; bus.rready = 1'b0;

      // timeout: pready held low, TIMEOUT=4
      @(posedge clk); #1 bus.pready = 1'b0; bus.prdata = 32'hDEAD_BEEF;
      issue_ar(32'h0000_0044);
      pen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.penable) pen++;
      end
      chk("to_penable_cycles", 64'(pen), 64'd4);
      chk("to_rvalid", 64'(bus.rvalid), 64'd1);
      chk("to_rresp", 64'(bus.rresp), 64'h2);
      chk("to_rdata", 64'(bus.rdata), 64'd0);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      @(posedge clk); #1 bus.pready = 1'b1;

      // slave error on a write, response stalled five cycles
      @(posedge clk); #1 bus.pslverr = 1'b1;
      issue_wr(32'h0000_0090, 32'h5555_AAAA, 4'hF);
      wait_bvalid("err_bvalid");
      bus.arvalid = 1'b1; bus.araddr = 32'h0000_0048;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) bus.arvalid = 1'b0;
         chk("err_bvalid_hold", 64'(bus.bvalid), 64'd1);
         chk("err_bresp_hold", 64'(bus.bresp), 64'h2);
         chk("err_psel_quiet", 64'(bus.psel), 64'd0);
      end
      chk("err_ar_captured", 64'(bus.arready), 64'd0);
      bus.bready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'hA5A5_0001;
      @(negedge clk);
      chk("err_bvalid_drop", 64'(bus.bvalid), 64'd0);
      bus.bready = 1'b0;
      wait_rvalid("err_next_rvalid");
      chk("err_next_rdata", 64'(bus.rdata), 64'hA5A5_0001);
      chk("err_next_rresp", 64'(bus.rresp), 64'd0);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;

      // asynchronous reset in the middle of ACCESS
      @(posedge clk); #1 bus.pready = 1'b0;
      issue_ar(32'h0000_004C);
      begin
         int k = 0;
         while (!bus.penable && k < 10) begin @(negedge clk); k++; end
      end
      chk("ar_mid_penable", 64'(bus.penable), 64'd1);
      #2 rstn = 1'b0;
      #1;
      chk("async_psel", 64'(bus.psel), 64'd0);
      chk("async_penable", 64'(bus.penable), 64'd0);
      chk("async_rvalid", 64'(bus.rvalid), 64'd0);
      @(posedge clk); #1 bus.pready = 1'b1; bus.prdata = 32'h0BAD_F00D;
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;
      issue_ar(32'h0000_0050);
      wait_rvalid("post_async_rvalid");
      chk("post_async_rdata", 64'(bus.rdata), 64'h0BAD_F00D);
      chk("post_async_rresp", 64'(bus.rresp), 64'd0);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
